// File: rtl/trojan_trigger_seq_if.sv
// Plaintext-load / encryption-done monitor bus for the Trojan trigger sequencer.
// pt is sampled only on cycles where pt_valid=1. done is a one-cycle pulse. Neither has a ready.
interface trojan_trigger_seq_if #(
    parameter int DATA_W = 128,
    parameter int CNT_W  = 8
);
    logic [DATA_W-1:0] pt;
    logic              pt_valid;
    logic              done;
    logic              r1;
    logic              r2;
    logic [2:0]        seq_state;
    logic [CNT_W-1:0]  done_cnt;

    modport master (
        output pt, pt_valid, done,
        input  r1, r2, seq_state, done_cnt
    );

    modport slave (
        input  pt, pt_valid, done,
        output r1, r2, seq_state, done_cnt
    );
endinterface

// File: rtl/trojan_trigger_seq.sv
// Trigger-condition generator: r1 arms after an ordered 4-plaintext signature,
// r2 follows once THRESH encryption-done pulses have been seen while armed.
module trojan_trigger_seq #(
    parameter int                DATA_W = 128,
    parameter logic [DATA_W-1:0] PAT0   = 128'h3243f6a8885a308d313198a2e0370734,
    parameter logic [DATA_W-1:0] PAT1   = 128'h00112233445566778899aabbccddeeff,
    parameter logic [DATA_W-1:0] PAT2   = 128'h00000000000000000000000000000000,
    parameter logic [DATA_W-1:0] PAT3   = 128'hffffffffffffffffffffffffffffffff,
    parameter int                THRESH = 4,
    parameter int                CNT_W  = 8
) (
    input logic                clk,
    input logic                rst,
    trojan_trigger_seq_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        M1    = 3'd1,
        M2    = 3'd2,
        M3    = 3'd3,
        ARMED = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

    state_t           state;
    logic             r1_q;
    logic             r2_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            r1_q  <= 1'b0;
            r2_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            // A PAT0 anywhere in a broken run restarts the match at M1.
            case (state)
                IDLE: if (bus.pt_valid) begin
                    if (bus.pt == PAT0) state <= M1;
                end
                M1: if (bus.pt_valid) begin
                    if (bus.pt == PAT1)      state <= M2;
                    else if (bus.pt == PAT0) state <= M1;
                    else                     state <= IDLE;
                end
                M2: if (bus.pt_valid) begin
                    if (bus.pt == PAT2)      state <= M3;
                    else if (bus.pt == PAT0) state <= M1;
                    else                     state <= IDLE;
                end
                M3: if (bus.pt_valid) begin
                    if (bus.pt == PAT3) begin
                        state <= ARMED;
                        r1_q  <= 1'b1;
                    end else if (bus.pt == PAT0) begin
                        state <= M1;
                    end else begin
                        state <= IDLE;
                    end
                end
                ARMED: state <= ARMED;
                default: state <= IDLE;
            endcase

            // Only done pulses seen while already armed count; the counter saturates.
            if (state == ARMED && bus.done && cnt_q != THRESH_C) begin
                cnt_q <= cnt_q + ONE_C;
                if (cnt_q == THRESH_C - ONE_C) r2_q <= 1'b1;
            end
        end
    end

    assign bus.r1        = r1_q;
    assign bus.r2        = r2_q;
    assign bus.seq_state = state;
    assign bus.done_cnt  = cnt_q;
endmodule

// File: doc/trojan_trigger_seq.md
Name: trojan_trigger_seq

Overview:
- Sequential trigger-condition generator for the AES Trojan trigger path.
- Sits directly upstream of the two-input AND trigger combiner and drives its r1 and r2 inputs.
- Monitors the AES plaintext load interface for an ordered 4-plaintext signature, then asserts r1 (sticky).
- After arming, counts completed encryptions and asserts r2 (sticky) once a threshold is reached, so the downstream trigger fires only after both conditions hold.

Parameters:
- DATA_W, 128, plaintext width in bits.
- PAT0, 128'h3243f6a8885a308d313198a2e0370734, first signature plaintext.
- PAT1, 128'h00112233445566778899aabbccddeeff, second signature plaintext.
- PAT2, 128'h00000000000000000000000000000000, third signature plaintext.
- PAT3, 128'hffffffffffffffffffffffffffffffff, fourth signature plaintext.
- THRESH, 4, number of encryption-done pulses after arming required to set r2 (legal range 1..255).
- CNT_W, 8, width of the done counter (must hold THRESH).

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- pt  input  DATA_W  plaintext presented to the AES core.
- pt_valid  input  1  one-cycle strobe; pt is sampled when high.
- done  input  1  one-cycle AES encryption-complete pulse.
- r1  output  1  signature-matched condition; sticky until rst.
- r2  output  1  done-count-reached condition; sticky until rst.
- seq_state  output  3  current FSM state encoding, for debug and verification.
- done_cnt  output  CNT_W  number of post-arming done pulses counted, saturating.

Behaviour:
- Reset: synchronous, active-high, highest priority. On any clk edge with rst=1: state=IDLE, r1=0, r2=0, done_cnt=0. Applies mid-sequence and after arming alike.
- FSM states and encodings: IDLE=0, M1=1, M2=2, M3=3, ARMED=4. Encodings 5-7 are unreachable; if entered, return to IDLE.
- Transitions occur only on cycles with pt_valid=1. With pt_valid=0, state holds regardless of pt.
- IDLE: pt==PAT0 -> M1; otherwise stay in IDLE.
- M1: pt==PAT1 -> M2; pt==PAT0 -> M1; otherwise -> IDLE.
- M2: pt==PAT2 -> M3; pt==PAT0 -> M1; otherwise -> IDLE.
- M3: pt==PAT3 -> ARMED; pt==PAT0 -> M1; otherwise -> IDLE.
- ARMED: terminal until rst; pt_valid and pt are ignored.
- Comparison is a full DATA_W-bit equality. The signature must be matched on consecutive valid samples; any non-matching valid sample breaks the run.
- r1 is a registered output equal to (state==ARMED). It rises on the same edge that samples PAT3 in M3, so it is visible 1 cycle after the matching pt_valid cycle.
- done counting is enabled only while state==ARMED at the sampling edge. A done pulse in the same cycle as the M3->ARMED transition is not counted.
- Each counted done increments done_cnt. done_cnt saturates at THRESH and never wraps.
- r2 is set on the edge where done_cnt transitions from THRESH-1 to THRESH, i.e. 1 cycle after the THRESH-th counted done. r2 stays high until rst.
- done pulses before arming are ignored; done_cnt remains 0.
- pt_valid and done may be high in the same cycle. Both are evaluated independently per the rules above.
- r1 and r2 never deassert without rst.

Test Plan:
- Reset check: hold rst=1 for 2 cycles with random pt, pt_valid and done -> r1=0, r2=0, seq_state=0, done_cnt=0.
- Full signature: pt_valid pulses with PAT0, PAT1, PAT2, PAT3 on consecutive valid cycles, with idle gaps of 0-3 cycles between them -> seq_state steps 1,2,3,4; r1=1 exactly 1 cycle after the PAT3 strobe.
- Broken run: PAT0, PAT1, 128'h1, PAT2, PAT3 -> state returns to 0 after 128'h1; r1 stays 0. Then PAT0, PAT0, PAT1, PAT2, PAT3 -> r1=1 (the repeated PAT0 keeps state at M1).
- Threshold: after arming, issue 4 done pulses -> done_cnt goes 1,2,3,4 and r2=1 one cycle after the 4th pulse; a 5th pulse leaves done_cnt=4 (saturated) and r2=1.
- Boundary cases: done pulses before arming, and done coincident with the PAT3 strobe -> neither is counted (done_cnt=0 the cycle after arming).
- Reset mid-operation: assert rst while state=ARMED with done_cnt=2 -> next cycle r1=0, r2=0, done_cnt=0, seq_state=0; the full sequence must be repeated to re-arm.
